// File: rtl/bps_sub4_if.sv
// bps_sub4_if: operand/result bundle for the 4-bit registered subtractor.
// Carries the scalar bit signals of the subtractor datapath:
//   a3..a0   minuend A (a3 = MSB)
//   b3..b0   subtrahend B (b3 = MSB)
//   c_in     carry-in to bit 0 (1 = no borrow-in)
//   s3..s0   registered difference S (s3 = MSB)
//   c_out    registered carry-out of bit 3 (1 = no borrow)
//   ovf      registered two's-complement overflow
//   zero     registered S == 0 flag
// master: drives operands, observes results. slave: the subtractor itself.
interface bps_sub4_if;
  logic a3, a2, a1, a0;
  logic b3, b2, b1, b0;
  logic c_in;
  logic s3, s2, s1, s0;
  logic c_out;
  logic ovf;
  logic zero;

  modport master (
    output a3, a2, a1, a0, b3, b2, b1, b0, c_in,
    input  s3, s2, s1, s0, c_out, ovf, zero
  );

  modport slave (
    input  a3, a2, a1, a0, b3, b2, b1, b0, c_in,
    output s3, s2, s1, s0, c_out, ovf, zero
  );
endinterface

// File: rtl/bps_sub4.sv
// bps_sub4: 4-bit binary parallel subtractor with registered outputs.
// Computes A - B as A + ~B + c_in through four rippled full-adder stages and
// registers the difference, carry-out, signed overflow and zero flag.
// c_in = 1 yields the true difference; c_in = 0 yields A - B - 1, which lets
// a wider subtractor be built by chaining c_out into the next c_in.
// Ports:
//   clk  rising-edge clock; operands are sampled every edge (no enable)
//   rst  synchronous active-high reset; clears all outputs to 0
//   bus  bps_sub4_if.slave: operands in, registered results out
// Latency is one clock, throughput one result per clock.
module bps_sub4 (
  input  logic       clk,
  input  logic       rst,
  bps_sub4_if.slave  bus
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] b_inv;
  logic [4:0] carry;

  logic [3:0] s_next;
  logic       c_out_next;
  logic       ovf_next;
  logic       zero_next;

  logic [3:0] s_reg;
  logic       c_out_reg;
  logic       ovf_reg;
  logic       zero_reg;

  assign a        = {bus.a3, bus.a2, bus.a1, bus.a0};
  assign b        = {bus.b3, bus.b2, bus.b1, bus.b0};
  assign b_inv    = ~b;
  assign carry[0] = bus.c_in;

  // Ripple chain: one full adder per bit on A and the inverted subtrahend.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
      assign s_next[gi]    = a[gi] ^ b_inv[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b_inv[gi]) | (a[gi] & carry[gi]) |
                             (b_inv[gi] & carry[gi]);
    end
  endgenerate

  assign c_out_next = carry[4];
  // Overflow only possible when operands differ in sign; it occurred when
  // the result's sign departs from the minuend's.
  assign ovf_next   = (a[3] ^ b[3]) & (s_next[3] ^ a[3]);
  assign zero_next  = ~(|s_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg     <= 4'b0000;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      s_reg     <= s_next;
      c_out_reg <= c_out_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
    end
  end

  assign bus.s3    = s_reg[3];
  assign bus.s2    = s_reg[2];
  assign bus.s1    = s_reg[1];
  assign bus.s0    = s_reg[0];
  assign bus.c_out = c_out_reg;
  assign bus.ovf   = ovf_reg;
  assign bus.zero  = zero_reg;

endmodule

// File: tb/tb_bps_sub4.sv
// tb_bps_sub4: directed and exhaustive check of the registered 4-bit subtractor.
// Operands are driven on the falling edge; results are sampled 1 time unit
// after the following rising edge, i.e. one clock of latency.
module tb_bps_sub4;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bps_sub4_if bus ();

  bps_sub4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic cin);
    {bus.a3, bus.a2, bus.a1, bus.a0} = a;
    {bus.b3, bus.b2, bus.b1, bus.b0} = b;
    bus.c_in = cin;
  endtask

  // Present operands on the falling edge, then wait past the next rising edge.
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    set_in(a, b, cin);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] es, input logic ec,
                           input logic eo, input logic ez);
    logic [3:0] s_obs;
    s_obs = {bus.s3, bus.s2, bus.s1, bus.s0};
    checks++;
    assert (s_obs === es) else begin
      errors++;
      $error("FAIL %s S: observed=%b expected=%b", tag, s_obs, es);
    end
    checks++;
    assert (bus.c_out === ec) else begin
      errors++;
      $error("FAIL %s c_out: observed=%b expected=%b", tag, bus.c_out, ec);
    end
    checks++;
    assert (bus.ovf === eo) else begin
      errors++;
      $error("FAIL %s ovf: observed=%b expected=%b", tag, bus.ovf, eo);
    end
    checks++;
    assert (bus.zero === ez) else begin
      errors++;
      $error("FAIL %s zero: observed=%b expected=%b", tag, bus.zero, ez);
    end
  endtask

  // Reference: arithmetic sum for S/c_out, signed-range test for overflow.
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
    logic [4:0] sum;
    int sa, sb, d;
    logic ov;
    sum = {1'b0, a} + {1'b0, ~b} + {4'b0000, cin};
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sb  = b[3] ? int'(b) - 16 : int'(b);
    d   = sa - sb - (cin ? 0 : 1);
    ov  = (d > 7) || (d < -8);
    return {sum[4], sum[3:0], ov, (sum[3:0] == 4'd0)};
  endfunction

  initial begin
    logic [6:0] exp_v;
    logic [3:0] va, vb;
    logic       vc;
    errors = 0;
    checks = 0;

    // Reset held two clocks with arbitrary operands.
    rst = 1'b1;
    set_in(4'($urandom), 4'($urandom), 1'($urandom));
    step(4'($urandom), 4'($urandom), 1'($urandom));
    check_out("reset1", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(4'($urandom), 4'($urandom), 1'($urandom));
    check_out("reset2", 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    step(4'd0, 4'd0, 1'b1);   check_out("0-0+1",  4'b0000, 1'b1, 1'b0, 1'b1);
    $display("vec A=0 B=0 cin=1");
    step(4'd5, 4'd3, 1'b1);   check_out("5-3",    4'b0010, 1'b1, 1'b0, 1'b0);
    $display("vec A=5 B=3 cin=1");
    step(4'd3, 4'd5, 1'b1);   check_out("3-5",    4'b1110, 1'b0, 1'b0, 1'b0);
    $display("vec A=3 B=5 cin=1");
    step(4'd0, 4'd0, 1'b0);   check_out("0-0-1",  4'b1111, 1'b0, 1'b0, 1'b0);
    $display("vec A=0 B=0 cin=0");
    step(4'd7, 4'd8, 1'b1);   check_out("7-8",    4'b1111, 1'b0, 1'b1, 1'b0);
    $display("vec A=7 B=8 cin=1");
    step(4'd8, 4'd1, 1'b1);   check_out("8-1",    4'b0111, 1'b1, 1'b1, 1'b0);
    $display("vec A=8 B=1 cin=1");
    step(4'hF, 4'd0, 1'b1);   check_out("F-0",    4'b1111, 1'b1, 1'b0, 1'b0);
    $display("vec A=F B=0 cin=1");
    step(4'd9, 4'd9, 1'b1);   check_out("9-9",    4'b0000, 1'b1, 1'b0, 1'b1);
    $display("vec A=9 B=9 cin=1");

    // Exhaustive sweep, with reset pulsed for one vector mid-way.
    for (int i = 0; i < 512; i++) begin
      va = 4'(i);
      vb = 4'(i >> 4);
      vc = 1'(i >> 8);
      rst = (i == 300);
      step(va, vb, vc);
      if (i == 300) begin
        check_out("sweep_reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        $display("sweep i=%0d reset", i);
      end else begin
        exp_v = model(va, vb, vc);
        check_out($sformatf("sweep a=%0d b=%0d cin=%0d", va, vb, vc),
                  exp_v[5:2], exp_v[6], exp_v[1], exp_v[0]);
        $display("sweep A=%0d B=%0d cin=%0d", va, vb, vc);
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
